// File: rtl/outport_arbiter.sv
// outport_arbiter: round-robin wormhole arbiter with downstream credit tracking for one output port.
// Optional watchdog on stalled grants: define OUTPORT_ARB_WATCHDOG_EN.
`ifndef NEXTHOPWIDTH
`define NEXTHOPWIDTH 5
`endif
module outport_arbiter #(
   parameter int NUM_IN  = `NEXTHOPWIDTH,
   parameter int CREDITS = 4,
   parameter int CW      = 3
`ifdef OUTPORT_ARB_WATCHDOG_EN
   , parameter int WD_BITS = 10
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IN-1:0] req,
   input  logic [NUM_IN-1:0] head_vld,
   input  logic [NUM_IN-1:0] head_tail,
   input  logic              credit_ret,
   output logic [NUM_IN-1:0] sel,
   output logic              oktosend,
   output logic              cred_err
`ifdef OUTPORT_ARB_WATCHDOG_EN
   , output logic            wd_err
`endif
);
   localparam int PW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t            state, state_nxt;
   logic [NUM_IN-1:0] sel_nxt;
   logic [PW-1:0]     rr_ptr, rr_nxt, own, own_nxt, gnt_idx, hi_idx, lo_idx;
   logic              hi_hit;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              cred_err_nxt, xfer, at_max;
   assign oktosend = state == LOCKED && cnt != '0;
   assign xfer     = oktosend && |(sel & head_vld);
   assign at_max   = cnt == CW'(CREDITS);
   // lowest requester at or above rr_ptr, else lowest requester overall (wrap)
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_hit = 1'b0;
      for (int j = NUM_IN - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_idx = PW'(j);
            if (PW'(j) >= rr_ptr) begin
               hi_idx = PW'(j);
               hi_hit = 1'b1;
            end
         end
      end
      gnt_idx = hi_hit ? hi_idx : lo_idx;
   end
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      own_nxt   = own;
      rr_nxt    = rr_ptr;
      if (state == IDLE) begin
         if (|req) begin
            state_nxt = LOCKED;
            sel_nxt   = NUM_IN'(1) << gnt_idx;
            own_nxt   = gnt_idx;
         end
      end else if (xfer && |(sel & head_tail)) begin
         state_nxt = IDLE;
         sel_nxt   = '0;
         rr_nxt    = own == PW'(NUM_IN - 1) ? '0 : own + PW'(1);
      end
   end
   assign cnt_nxt = (xfer && !credit_ret) ? cnt - CW'(1) :
                    (!xfer && credit_ret && !at_max) ? cnt + CW'(1) : cnt;
   assign cred_err_nxt = cred_err | (credit_ret & at_max);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= '0;
         own      <= '0;
         rr_ptr   <= '0;
         cnt      <= CW'(CREDITS);
         cred_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         own      <= own_nxt;
         rr_ptr   <= rr_nxt;
         cnt      <= cnt_nxt;
         cred_err <= cred_err_nxt;
      end
   end
`ifdef OUTPORT_ARB_WATCHDOG_EN
   logic [WD_BITS-1:0] wd_cnt, wd_nxt;
   // release always coincides with a transfer, so IDLE entry clears too
   assign wd_nxt = (state != LOCKED || xfer) ? '0 : &wd_cnt ? wd_cnt : wd_cnt + WD_BITS'(1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         wd_err <= 1'b0;
      end else begin
         wd_cnt <= wd_nxt;
         wd_err <= wd_err | &wd_nxt;
      end
   end
`endif
endmodule

// File: tb/tb_outport_arbiter.sv
// tb_outport_arbiter: directed scenarios for the output-port arbiter (default build, 5 inputs, 4 credits).
module tb_outport_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] req = '0, head_vld = '0, head_tail = '0;
   logic       credit_ret = 1'b0;
   logic [4:0] sel;
   logic       oktosend, cred_err;
   int         n_checks = 0, n_fail = 0;

   outport_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req(req), .head_vld(head_vld), .head_tail(head_tail),
      .credit_ret(credit_ret), .sel(sel), .oktosend(oktosend), .cred_err(cred_err)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      req = '0; head_vld = '0; head_tail = '0; credit_ret = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (sel !== 5'b0) begin n_fail++; $display("FAIL reset_sel got=%b exp=%b", sel, 5'b0); end
      n_checks++; if (oktosend !== 1'b0) begin n_fail++; $display("FAIL reset_ok got=%b exp=0", oktosend); end
      n_checks++; if (cred_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", cred_err); end
      n_checks++; if (dut.cnt !== 3'd4) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=4", dut.cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      req = 5'b00100; head_vld = 5'b00100; head_tail = 5'b00100;
      @(negedge clk);
      n_checks++; if (sel !== 5'b00100) begin n_fail++; $display("FAIL single_sel got=%b exp=%b", sel, 5'b00100); end
      n_checks++; if (oktosend !== 1'b1) begin n_fail++; $display("FAIL single_ok got=%b exp=1", oktosend); end
      req = '0;
      @(negedge clk);
      n_checks++; if (sel !== 5'b0) begin n_fail++; $display("FAIL single_rel got=%b exp=%b", sel, 5'b0); end
      n_checks++; if (dut.cnt !== 3'd3) begin n_fail++; $display("FAIL single_cnt got=%0d exp=3", dut.cnt); end
      n_checks++; if (oktosend !== 1'b0) begin n_fail++; $display("FAIL single_ok_idle got=%b exp=0", oktosend); end
   endtask

   task automatic test_round_robin();
      logic [4:0] order [4];
      order[0] = 5'b00001; order[1] = 5'b00010; order[2] = 5'b10000; order[3] = 5'b00001;
      do_reset();
      req = 5'b10011; head_vld = 5'b10011;
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         n_checks++; if (sel !== order[p]) begin n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", p, sel, order[p]); end
         n_checks++; if (oktosend !== 1'b1) begin n_fail++; $display("FAIL rr_ok%0d got=%b exp=1", p, oktosend); end
         head_tail = '0; credit_ret = 1'b0;
         @(negedge clk);
         n_checks++; if (dut.cnt !== 3'd3) begin n_fail++; $display("FAIL rr_cnt1_%0d got=%0d exp=3", p, dut.cnt); end
         credit_ret = 1'b1;
         @(negedge clk);
         n_checks++; if (sel !== order[p]) begin n_fail++; $display("FAIL rr_hold%0d got=%b exp=%b", p, sel, order[p]); end
         head_tail = order[p];
         @(negedge clk);
         n_checks++; if (sel !== 5'b0) begin n_fail++; $display("FAIL rr_bubble%0d got=%b exp=%b", p, sel, 5'b0); end
         n_checks++; if (dut.cnt !== 3'd3) begin n_fail++; $display("FAIL rr_cnt3_%0d got=%0d exp=3", p, dut.cnt); end
         head_tail = '0;
      end
      req = '0; credit_ret = 1'b0;
   endtask

   task automatic test_credit_stall();
      do_reset();
      req = 5'b00001; head_vld = 5'b00001;
      @(negedge clk);
      n_checks++; if (sel !== 5'b00001) begin n_fail++; $display("FAIL stall_sel got=%b exp=%b", sel, 5'b00001); end
      req = '0;
      repeat (4) @(negedge clk);
      n_checks++; if (dut.cnt !== 3'd0) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=0", dut.cnt); end
      n_checks++; if (oktosend !== 1'b0) begin n_fail++; $display("FAIL stall_ok got=%b exp=0", oktosend); end
      @(negedge clk);
      n_checks++; if (sel !== 5'b00001) begin n_fail++; $display("FAIL stall_hold got=%b exp=%b", sel, 5'b00001); end
      credit_ret = 1'b1;
      @(negedge clk);
      credit_ret = 1'b0;
      n_checks++; if (oktosend !== 1'b1) begin n_fail++; $display("FAIL stall_resume got=%b exp=1", oktosend); end
      n_checks++; if (dut.cnt !== 3'd1) begin n_fail++; $display("FAIL stall_cnt1 got=%0d exp=1", dut.cnt); end
      @(negedge clk);
      n_checks++; if (dut.cnt !== 3'd0) begin n_fail++; $display("FAIL stall_cnt0 got=%0d exp=0", dut.cnt); end
      n_checks++; if (oktosend !== 1'b0) begin n_fail++; $display("FAIL stall_ok2 got=%b exp=0", oktosend); end
   endtask

   task automatic test_credit_simul();
      do_reset();
      req = 5'b00010; head_vld = 5'b00010;
      @(negedge clk);
      n_checks++; if (sel !== 5'b00010) begin n_fail++; $display("FAIL simul_sel got=%b exp=%b", sel, 5'b00010); end
      req = '0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (dut.cnt !== 3'd2) begin n_fail++; $display("FAIL simul_cnt2 got=%0d exp=2", dut.cnt); end
      credit_ret = 1'b1;
      @(negedge clk);
      n_checks++; if (dut.cnt !== 3'd2) begin n_fail++; $display("FAIL simul_same got=%0d exp=2", dut.cnt); end
      head_vld = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (dut.cnt !== 3'd4) begin n_fail++; $display("FAIL simul_full got=%0d exp=4", dut.cnt); end
      n_checks++; if (cred_err !== 1'b0) begin n_fail++; $display("FAIL simul_noerr got=%b exp=0", cred_err); end
      @(negedge clk);
      credit_ret = 1'b0;
      n_checks++; if (dut.cnt !== 3'd4) begin n_fail++; $display("FAIL simul_sat got=%0d exp=4", dut.cnt); end
      n_checks++; if (cred_err !== 1'b1) begin n_fail++; $display("FAIL simul_err got=%b exp=1", cred_err); end
      @(negedge clk);
      n_checks++; if (cred_err !== 1'b1) begin n_fail++; $display("FAIL simul_sticky got=%b exp=1", cred_err); end
   endtask

   task automatic test_owner_empty();
      do_reset();
      req = 5'b00100; head_vld = 5'b00100;
      @(negedge clk);
      n_checks++; if (sel !== 5'b00100) begin n_fail++; $display("FAIL empty_sel got=%b exp=%b", sel, 5'b00100); end
      req = '0;
      @(negedge clk);
      req = 5'b01000; head_vld = 5'b01000;
      repeat (3) @(negedge clk);
      n_checks++; if (sel !== 5'b00100) begin n_fail++; $display("FAIL empty_hold got=%b exp=%b", sel, 5'b00100); end
      n_checks++; if (dut.cnt !== 3'd3) begin n_fail++; $display("FAIL empty_cnt got=%0d exp=3", dut.cnt); end
      head_vld = 5'b01100; head_tail = 5'b00100;
      @(negedge clk);
      n_checks++; if (sel !== 5'b0) begin n_fail++; $display("FAIL empty_rel got=%b exp=%b", sel, 5'b0); end
      n_checks++; if (dut.cnt !== 3'd2) begin n_fail++; $display("FAIL empty_cnt2 got=%0d exp=2", dut.cnt); end
      head_tail = '0;
      @(negedge clk);
      n_checks++; if (sel !== 5'b01000) begin n_fail++; $display("FAIL empty_next got=%b exp=%b", sel, 5'b01000); end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 5'b10000; head_vld = 5'b10000;
      @(negedge clk);
      n_checks++; if (sel !== 5'b10000) begin n_fail++; $display("FAIL arst_sel got=%b exp=%b", sel, 5'b10000); end
      req = '0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (sel !== 5'b0) begin n_fail++; $display("FAIL arst_sel0 got=%b exp=%b", sel, 5'b0); end
      n_checks++; if (oktosend !== 1'b0) begin n_fail++; $display("FAIL arst_ok got=%b exp=0", oktosend); end
      n_checks++; if (dut.cnt !== 3'd4) begin n_fail++; $display("FAIL arst_cnt got=%0d exp=4", dut.cnt); end
      @(negedge clk) rst_n = 1'b1;
      head_vld = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_credit_stall();
      test_credit_simul();
      test_owner_empty();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/outport_arbiter.md
Name: outport_arbiter

Overview:
- Per-output-port arbiter of the NoC switch.
- Picks one input port round-robin and locks onto it from head flit to tail flit.
- Tracks downstream buffer credits and drives this port's one-hot select and ok-to-send.
- Its sel and oktosend feed the input-side FIFO read-enable logic of every input port.

Parameters:
- NUM_IN, default `NEXTHOPWIDTH (5): number of input ports competing for this output.
- CREDITS, default 4: downstream buffer depth in flits; reset value of the credit counter.
- CW, default 3: credit counter width; must hold CREDITS, i.e. 2^CW > CREDITS.

Ports:
- clk  in  1  switch clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_IN  req[i]=1: input i FIFO head is a head flit routed to this output.
- head_vld  in  NUM_IN  head_vld[i]=1: input i FIFO non-empty (head flit valid).
- head_tail  in  NUM_IN  head_tail[i]=1: input i head flit is a tail flit (single-flit packets have head and tail set).
- credit_ret  in  1  one-cycle pulse; downstream freed one flit slot.
- sel  out  NUM_IN  one-hot grant, bit i = input i owns this output; all-zero when idle.
- oktosend  out  1  granted input may transfer a flit this cycle.
- cred_err  out  1  sticky; credit returned while counter already at CREDITS.

Behaviour:
- Reset (rst_n low, async): state=IDLE, sel=0, rr_ptr=0, credit counter=CREDITS, oktosend=0, cred_err=0.
- States:
  - IDLE: if any req[i], grant the first requester at or after rr_ptr, searching upward and wrapping. Register sel=onehot(i) and go to LOCKED on the next edge. With no req, stay IDLE with sel=0.
  - LOCKED: hold sel unchanged. Ignore req from all inputs, including new requests from the owner.
- Arbitration latency: 1 cycle from req seen in IDLE to sel valid.
- oktosend = (state==LOCKED) && (credit counter != 0). Decoded from registers only; no combinational path from req/head_vld.
- Transfer (xfer) = oktosend && |(sel & head_vld).
  - The input FIFO pops on the same cycle.
  - Arbiter side-effect: credit counter decrements by 1.
- Release: on xfer with |(sel & head_tail):
  - next state=IDLE, sel=0;
  - rr_ptr = (granted index + 1), wrapping NUM_IN-1 to 0.
- Bubble: exactly one idle cycle between consecutive packets on the same output (release cycle, then arbitration cycle). No back-to-back grant.
- Credit counter:
  - xfer and credit_ret in the same cycle: unchanged.
  - xfer only: decrement.
  - credit_ret only: increment, saturating at CREDITS.
  - credit_ret at CREDITS: value stays CREDITS and cred_err sets; cleared only by reset.
  - Counter 0 while LOCKED: oktosend=0, grant held, sel unchanged until a credit returns.
- Owner FIFO empty while LOCKED (head_vld[i]=0): no xfer, no credit change, grant held. Wormhole semantics, no preemption.
- Width rules: rr_ptr is clog2(NUM_IN) bits with explicit wrap at NUM_IN-1 (NUM_IN need not be a power of 2). Credit arithmetic is CW bits with no wrap.
- Reset asserted mid-packet: immediate return to IDLE, credits=CREDITS, sel=0. The rest of the packet is the system's concern.

Optional Feature:
- Macro OUTPORT_ARB_WATCHDOG_EN.
- When defined, adds:
  - parameter WD_BITS, default 10;
  - output wd_err (1 bit, sticky, reset 0).
- Watchdog counter (WD_BITS wide):
  - counts cycles in LOCKED with no xfer;
  - cleared on any xfer and on entry to IDLE;
  - on reaching all-ones, wd_err sets; the counter holds at all-ones.
- wd_err does not alter the grant.
- When undefined: no wd_err port, no counter logic, behaviour otherwise identical.

Test Plan:
- Reset, then req=5'b00100 with head_vld[2]=1, head_tail[2]=1 -> sel=5'b00100 one cycle later, oktosend=1. Single xfer, then sel=0 and credits=3 next cycle.
- req=5'b10011 held, rr_ptr=0, 3-flit packets -> grant order 0,1,4,0. Exactly one idle cycle between packets; credits decrement per flit.
- CREDITS=4, 6-flit packet, no credit_ret -> 4 xfers, then oktosend=0 with sel held. credit_ret pulse -> one more xfer next cycle.
- credit_ret and xfer in the same cycle with credits=2 -> credits stay 2. credit_ret with credits=4 -> stays 4, cred_err=1.
- Owner head_vld dropped for 3 cycles mid-packet while req[3]=1 from another input -> no grant change, no credit change, packet resumes. Input 3 is granted only after the tail.
- rst_n pulsed low asynchronously mid-packet (between edges) -> sel=0, oktosend=0, credits=CREDITS immediately. With OUTPORT_ARB_WATCHDOG_EN and WD_BITS=4, a 15-cycle stall sets wd_err.
